otter_intr_ctrl: RTL

Multi-source interrupt controller that sits in front of the OTTER CU_FSM interrupt input.
- Latches rising edges from NUM_SRC peripheral lines into pending bits, applies a software mask and raises a single intr request to the FSM.
- On int_taken, records the winning source in a readable ID register.
- Holds off further requests until mret_exec.
- Software configures and inspects it through memory-mapped registers on the IOBUS.

---
 rtl/otter_intr_ctrl_if.sv | 26 ++
 rtl/otter_intr_ctrl.sv | 125 ++++++++++++
 2 files changed

// File: rtl/otter_intr_ctrl_if.sv
// Purpose : bundles the IOBUS register port and the CU_FSM interrupt handshake.
// Latency : n/a (wires only); cpu_intr is registered inside the controller.
// Backpressure: none; int_taken / mret_exec are single-cycle pulses from the FSM.
// Signals : iobus_addr/iobus_out/iobus_wr (store side), iobus_rd_data (load side),
//           int_taken/mret_exec (FSM -> ctrl), cpu_intr (ctrl -> FSM).
interface otter_intr_ctrl_if;
  logic [31:0] iobus_addr;
  logic [31:0] iobus_out;
  logic        iobus_wr;
  logic [31:0] iobus_rd_data;
  logic        int_taken;
  logic        mret_exec;
  logic        cpu_intr;

  // CPU / bus side
  modport master (
    output iobus_addr, iobus_out, iobus_wr, int_taken, mret_exec,
    input  iobus_rd_data, cpu_intr
  );

  // Interrupt controller side
  modport slave (
    input  iobus_addr, iobus_out, iobus_wr, int_taken, mret_exec,
    output iobus_rd_data, cpu_intr
  );
endinterface

// File: rtl/otter_intr_ctrl.sv
// Purpose : multi-source edge-latched interrupt controller in front of CU_FSM.
// Latency : edge sampled at clock k -> PENDING at k -> cpu_intr high after k+1.
// Backpressure: one request outstanding; new edges queue in PENDING until mret.
// Ports   : clk_i, rst_ni (async active-low), irq_src_i[NUM_SRC],
//           bus (slave modport): IOBUS regs PENDING(+0) MASK(+4) ACTIVE(+8),
//           int_taken/mret_exec in, cpu_intr out.
module otter_intr_ctrl #(
  parameter int          NUM_SRC   = 8,
  parameter logic [31:0] BASE_ADDR = 32'h1100_0100
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_SRC-1:0] irq_src_i,
  otter_intr_ctrl_if.slave   bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  localparam logic [31:0] ADDR_PEND = BASE_ADDR;
  localparam logic [31:0] ADDR_MASK = BASE_ADDR + 32'h4;
  localparam logic [31:0] ADDR_ACT  = BASE_ADDR + 32'h8;

  logic [NUM_SRC-1:0] irq_prev_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic               act_vld_q, act_vld_d;
  logic [3:0]         act_id_q, act_id_d;
  logic [1:0]         state_q, state_d;

  logic [NUM_SRC-1:0] edge_vec;
  logic [NUM_SRC-1:0] req_vec;
  logic [NUM_SRC-1:0] w1c_vec;
  logic [NUM_SRC-1:0] win_oh;
  logic [NUM_SRC-1:0] cap_clr;
  logic [3:0]         win_id;
  logic               capture;

  assign edge_vec = irq_src_i & ~irq_prev_q;
  assign req_vec  = pending_q & mask_q;
  assign w1c_vec  = (bus.iobus_wr && bus.iobus_addr == ADDR_PEND) ?
                    bus.iobus_out[NUM_SRC-1:0] : '0;

  // Lowest set index wins: scan from the top so the last hit is the lowest.
  always_comb begin
    win_id = 4'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req_vec[i]) win_id = 4'(i);
    end
    win_oh = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      win_oh[i] = (4'(i) == win_id);
    end
  end

  // A withdrawn request (req_vec empty) takes precedence over int_taken.
  assign capture = (state_q == ST_REQ) && bus.int_taken && (req_vec != '0);
  assign cap_clr = capture ? win_oh : '0;

  // New edges are OR-ed last so a same-cycle set beats any clear.
  assign pending_d = (pending_q & ~(w1c_vec | cap_clr)) | edge_vec;

  // Capture above already used mask_q, so a concurrent MASK write lands after.
  assign mask_d = (bus.iobus_wr && bus.iobus_addr == ADDR_MASK) ?
                  bus.iobus_out[NUM_SRC-1:0] : mask_q;

  always_comb begin
    state_d   = state_q;
    act_vld_d = act_vld_q;
    act_id_d  = act_id_q;
    case (state_q)
      ST_IDLE: begin
        if (req_vec != '0) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (req_vec == '0) begin
          state_d = ST_IDLE;
        end else if (bus.int_taken) begin
          state_d   = ST_SERVICE;
          act_vld_d = 1'b1;
          act_id_d  = win_id;
        end
      end
      ST_SERVICE: begin
        if (bus.mret_exec) begin
          state_d   = ST_IDLE;
          act_vld_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_prev_q <= '0;
      pending_q  <= '0;
      mask_q     <= '0;
      act_vld_q  <= 1'b0;
      act_id_q   <= 4'd0;
      state_q    <= ST_IDLE;
    end else begin
      irq_prev_q <= irq_src_i;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      act_vld_q  <= act_vld_d;
      act_id_q   <= act_id_d;
      state_q    <= state_d;
    end
  end

  assign bus.cpu_intr = (state_q == ST_REQ);

  always_comb begin
    bus.iobus_rd_data = 32'h0;
    case (bus.iobus_addr)
      ADDR_PEND: bus.iobus_rd_data = 32'(pending_q);
      ADDR_MASK: bus.iobus_rd_data = 32'(mask_q);
      ADDR_ACT:  bus.iobus_rd_data = {act_vld_q, 27'h0, act_id_q};
      default:   bus.iobus_rd_data = 32'h0;
    endcase
  end

endmodule
